// File: rtl/regmem_sequencer_if.sv
// Command, RegisterMemory and response signals of regmem_sequencer.
// slave = sequencer side, master = control unit / memory side.
interface regmem_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic [1:0]        cmd_fn;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [1:0]        mem_select_fn;
  logic              mem_fn_valid;
  logic [DATA_W-1:0] mem_data_out;
  logic [3:0]        mem_flag;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flag;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_fn,
    input  mem_data_out, mem_flag,
    output cmd_ready,
    output mem_address, mem_data_in, mem_read_en, mem_write_en,
    output mem_select_fn, mem_fn_valid,
    output rsp_valid, rsp_data, rsp_flag, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_fn,
    output mem_data_out, mem_flag,
    input  cmd_ready,
    input  mem_address, mem_data_in, mem_read_en, mem_write_en,
    input  mem_select_fn, mem_fn_valid,
    input  rsp_valid, rsp_data, rsp_flag, busy
  );
endinterface

// File: rtl/regmem_sequencer.sv
// Single-command sequencer driving RegisterMemory as fixed phase sequences.
// Define SEQ_TRISTATE_FN_EN to float mem_select_fn (2'bzz) while no function is live.
module regmem_sequencer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RES_ADDR = 2
) (
  input logic             clk,
  input logic             rst,
  regmem_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FN   = 3'd1;
  localparam logic [2:0] S_FNG  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [ADDR_W-1:0] RES = ADDR_W'(RES_ADDR);

  logic [2:0]        state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] cap_q;
  logic [3:0]        flag_q;

  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_in_q;
  logic              read_en_q;
  logic              write_en_q;
  logic [1:0]        sel_q;
  logic              fn_valid_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        rsp_flag_q;

  // Every mem_* output is loaded on the edge that enters the phase using it,
  // so the case below is keyed on the state being left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LDI;
      dst_q       <= '0;
      cap_q       <= '0;
      flag_q      <= '0;
      address_q   <= '0;
      data_in_q   <= '0;
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      sel_q       <= '0;
      fn_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= '0;
    end else begin
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      fn_valid_q  <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            dst_q <= bus.cmd_dst;
            cap_q <= bus.cmd_imm;
            case (bus.cmd_op)
              OP_LDI: begin
                state_q    <= S_WR;
                address_q  <= bus.cmd_dst;
                data_in_q  <= bus.cmd_imm;
                write_en_q <= 1'b1;
              end
              OP_ALU: begin
                state_q    <= S_FN;
                sel_q      <= bus.cmd_fn;
                fn_valid_q <= 1'b1;
              end
              default: begin
                state_q   <= S_RD;
                address_q <= bus.cmd_src;
                read_en_q <= 1'b1;
              end
            endcase
          end
        end
        S_FN: state_q <= S_FNG;
        S_FNG: begin
          flag_q    <= bus.mem_flag;
          state_q   <= S_RD;
          address_q <= RES;
          read_en_q <= 1'b1;
        end
        S_RD: begin
          cap_q <= bus.mem_data_out;
          if (op_q == OP_READ || (op_q == OP_ALU && dst_q == RES)) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mem_data_out;
            rsp_flag_q  <= (op_q == OP_ALU) ? flag_q : 4'b0000;
          end else begin
            state_q    <= S_WR;
            address_q  <= dst_q;
            data_in_q  <= bus.mem_data_out;
            write_en_q <= 1'b1;
          end
        end
        S_WR: state_q <= S_GAP;
        S_GAP: begin
          state_q     <= S_DONE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= cap_q;
          rsp_flag_q  <= (op_q == OP_ALU) ? flag_q : 4'b0000;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_address   = address_q;
  assign bus.mem_data_in   = data_in_q;
  assign bus.mem_read_en   = read_en_q;
  assign bus.mem_write_en  = write_en_q;
  assign bus.mem_fn_valid  = fn_valid_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_flag      = rsp_flag_q;

`ifdef SEQ_TRISTATE_FN_EN
  assign bus.mem_select_fn = fn_valid_q ? sel_q : 2'bzz;
`else
  assign bus.mem_select_fn = sel_q;
`endif

endmodule

// File: tb/tb_regmem_sequencer.sv
// Randomized self-checking bench for regmem_sequencer with a behavioural
// RegisterMemory stand-in and a per-command reference model.
module tb_regmem_sequencer;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 8;
  localparam int unsigned RES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regmem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regmem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RES_ADDR(RES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU of the register file: returns {flag, result}; flag = {0, neg, zero, carry}
  function automatic logic [11:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] fn);
    logic [8:0] w;
    case (fn)
      2'b00:   w = {1'b0, a} + {1'b0, b};
      2'b01:   w = {1'b0, a} - {1'b0, b};
      2'b10:   w = {1'b0, a & b};
      default: w = {1'b0, a ^ b};
    endcase
    return {1'b0, w[7], (w[7:0] == 8'd0), w[8], w[7:0]};
  endfunction

  // RegisterMemory stand-in: ALU reads R0,R1 and writes RES when fn_valid
  logic [7:0] mem_regs [32];
  logic [3:0] mem_flag_q;
  logic       mem_clear;
  assign bus.mem_data_out = mem_regs[bus.mem_address];
  assign bus.mem_flag     = mem_flag_q;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem_regs[i] <= 8'd0;
      mem_flag_q <= 4'd0;
    end else begin
      if (bus.mem_write_en) mem_regs[bus.mem_address] <= bus.mem_data_in;
      if (bus.mem_fn_valid)
        {mem_flag_q, mem_regs[RES]} <= alu_calc(mem_regs[0], mem_regs[1], bus.mem_select_fn);
    end
  end

  // Cumulative phase monitor, sampled mid-cycle
  int         wr_cnt = 0, rd_cnt = 0, fn_cnt = 0, rsp_cnt = 0;
  logic [4:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [1:0] fn_sel;
  always @(negedge clk) begin
    if (bus.mem_write_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.mem_address;
      wr_data <= bus.mem_data_in;
    end
    if (bus.mem_read_en) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= bus.mem_address;
    end
    if (bus.mem_fn_valid) begin
      fn_cnt <= fn_cnt + 1;
      fn_sel <= bus.mem_select_fn;
    end
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  logic [7:0] ref_regs [32];

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] dst, input logic [4:0] src,
                         input logic [7:0] imm, input logic [1:0] fn, input bit hold);
    int exp_lat, exp_wr, exp_rd, exp_fn;
    int wr0, rd0, fn0, rsp0, lat;
    bit got;
    logic [7:0]  exp_data;
    logic [3:0]  exp_flag;
    logic [4:0]  exp_rd_addr;
    logic [11:0] fr;
    exp_flag = 4'd0; exp_rd = 0; exp_wr = 0; exp_fn = 0; exp_rd_addr = src;
    case (op)
      2'b00: begin exp_lat = 3; exp_wr = 1; exp_data = imm; end
      2'b01: begin exp_lat = 4; exp_rd = 1; exp_wr = 1; exp_data = ref_regs[src]; end
      2'b11: begin exp_lat = 2; exp_rd = 1; exp_data = ref_regs[src]; end
      default: begin
        fr = alu_calc(ref_regs[0], ref_regs[1], fn);
        exp_flag = fr[11:8];
        exp_data = fr[7:0];
        ref_regs[RES] = exp_data;
        exp_fn = 1; exp_rd = 1; exp_rd_addr = 5'(RES);
        if (dst == 5'(RES)) exp_lat = 4;
        else begin exp_lat = 6; exp_wr = 1; end
      end
    endcase
    if (exp_wr != 0) ref_regs[dst] = exp_data;

    @(negedge clk);
    check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    wr0 = wr_cnt; rd0 = rd_cnt; fn0 = fn_cnt; rsp0 = rsp_cnt;
    bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src = src;
    bus.cmd_imm = imm; bus.cmd_fn = fn; bus.cmd_valid = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) got = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("rsp_flag", 32'(bus.rsp_flag), 32'(exp_flag));
    check("busy_in_done", 32'(bus.busy), 32'd1);
    check("write_cycles", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("read_cycles", 32'(rd_cnt - rd0), 32'(exp_rd));
    check("fn_cycles", 32'(fn_cnt - fn0), 32'(exp_fn));
    if (exp_wr != 0) begin
      check("write_addr", 32'(wr_addr), 32'(dst));
      check("write_data", 32'(wr_data), 32'(exp_data));
    end
    if (exp_rd != 0) check("read_addr", 32'(rd_addr), 32'(exp_rd_addr));
    if (exp_fn != 0) check("select_fn", 32'(fn_sel), 32'(fn));
    check("reg_dst", 32'(mem_regs[dst]), 32'(ref_regs[dst]));
    @(negedge clk);
    check("ready_after_done", 32'(bus.cmd_ready), 32'd1);
    check("rsp_pulse_count", 32'(rsp_cnt - rsp0), 32'd1);
  endtask

  logic [1:0] idle_sel;
  int         rsp_before;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'd0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_dst = '0;
    bus.cmd_src = '0; bus.cmd_imm = '0; bus.cmd_fn = 2'b00;
    mem_clear = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mem_clear = 1'b0;
    @(negedge clk);

`ifdef SEQ_TRISTATE_FN_EN
    idle_sel = 2'bzz;
`else
    idle_sel = 2'b00;
`endif
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_address", 32'(bus.mem_address), 32'd0);
    check("rst_data_in", 32'(bus.mem_data_in), 32'd0);
    check("rst_read_en", 32'(bus.mem_read_en), 32'd0);
    check("rst_write_en", 32'(bus.mem_write_en), 32'd0);
    check("rst_fn_valid", 32'(bus.mem_fn_valid), 32'd0);
    check("rst_select_fn", 32'(bus.mem_select_fn), 32'(idle_sel));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_flag", 32'(bus.rsp_flag), 32'd0);

    run_cmd(2'b00, 5'd4, 5'd0, 8'd141, 2'b00, 1'b0);
    run_cmd(2'b00, 5'd5, 5'd0, 8'd208, 2'b00, 1'b0);
    run_cmd(2'b01, 5'd1, 5'd5, 8'd0, 2'b00, 1'b0);
    check("mov_r1", 32'(mem_regs[1]), 32'd208);
    run_cmd(2'b00, 5'd0, 5'd0, 8'd200, 2'b00, 1'b0);
    run_cmd(2'b00, 5'd1, 5'd0, 8'd149, 2'b00, 1'b0);
    run_cmd(2'b10, 5'd0, 5'd0, 8'd0, 2'b00, 1'b0);
    check("alu_r0", 32'(mem_regs[0]), 32'd93);
    check("alu_idle_select_fn", 32'(bus.mem_select_fn), 32'(idle_sel));
    run_cmd(2'b10, 5'd2, 5'd0, 8'd0, 2'b00, 1'b0);
    run_cmd(2'b00, 5'd9, 5'd0, 8'd32, 2'b00, 1'b0);
    run_cmd(2'b11, 5'd3, 5'd9, 8'd0, 2'b00, 1'b1);
    run_cmd(2'b01, 5'd9, 5'd9, 8'd0, 2'b00, 1'b0);

    // Reset during the WR phase of a MOV: write must drop without a clock edge
    @(negedge clk);
    rsp_before = rsp_cnt;
    bus.cmd_op = 2'b01; bus.cmd_src = 5'd4; bus.cmd_dst = 5'd7; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mov_wr_phase", 32'(bus.mem_write_en), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_write_en", 32'(bus.mem_write_en), 32'd0);
    check("rst_mid_read_en", 32'(bus.mem_read_en), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_no_write", 32'(mem_regs[7]), 32'(ref_regs[7]));
    run_cmd(2'b00, 5'd7, 5'd0, 8'd55, 2'b00, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regmem_sequencer.md
# regmem_sequencer

Hardware command sequencer that drives the RegisterMemory port (address, data_in, read_en, write_en, Select_Fn) and collects data_out and flag. It replaces hand-timed stimulus with a single-command valid/ready front end. It issues load-immediate, register move, ALU operate-and-move, and register read as fixed multi-cycle phase sequences. It sits between a control unit and the execution unit's register memory.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 8, register data width
- RES_ADDR, 2, register the ALU writes its result to
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LDI, 01 MOV, 10 ALU, 11 READ
- cmd_dst  in  ADDR_W  destination register
- cmd_src  in  ADDR_W  source register (MOV, READ)
- cmd_imm  in  DATA_W  immediate (LDI)
- cmd_fn  in  2  ALU function code (ALU)
- mem_address  out  ADDR_W  to RegisterMemory address
- mem_data_in  out  DATA_W  to RegisterMemory data_in
- mem_read_en  out  1  to read_en
- mem_write_en  out  1  to write_en
- mem_select_fn  out  2  to Select_Fn
- mem_fn_valid  out  1  high while mem_select_fn carries a live function
- mem_data_out  in  DATA_W  from data_out
- mem_flag  in  4  from flag
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  value written or read
- rsp_flag  out  4  flag captured (ALU only, else 0)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FN, FNG, RD, WR, GAP, DONE. Command fields latched on accept (cmd_valid && cmd_ready at a rising edge).
- LDI: WR(address=dst, data_in=imm, write_en=1) -> GAP -> DONE. rsp_data=imm.
- MOV: RD(address=src, read_en=1) -> WR(address=dst, data_in=captured) -> GAP -> DONE. rsp_data=captured.
- READ: RD(address=src) -> DONE. rsp_data=captured. No write.
- ALU: FN(select_fn=fn, fn_valid=1) -> FNG(fn_valid=0) -> RD(address=RES_ADDR) -> WR(dst) -> GAP -> DONE. If dst==RES_ADDR, RD goes straight to DONE. rsp_flag is captured at the end of FNG.
- Capture: mem_data_out is sampled on the rising edge that leaves RD.
- Outside active phases: read_en=0, write_en=0, fn_valid=0. mem_address and mem_data_in hold their last values.
- DONE always returns to IDLE.
- MOV with src==dst executes normally. All 2^ADDR_W addresses pass through unchecked.
- cmd_valid while not ready is ignored. No queuing.
- rsp_valid has no backpressure.

## Timing
- Reset values: IDLE, cmd_ready=1, busy=0, mem_address=0, mem_data_in=0, read_en=0, write_en=0, fn_valid=0, select_fn idle value, rsp_valid=0, rsp_data=0, rsp_flag=0.
- All mem_* outputs are registered and change only on the edge entering a state.
- Each state lasts exactly one cycle.
- Accept edge T. First phase is in cycle T+1. rsp_valid is high in the DONE cycle.
- Latencies to rsp_valid: LDI T+3, MOV T+4, READ T+2, ALU T+6 (T+4 if dst==RES_ADDR).
- cmd_ready is high again the cycle after DONE. Minimum command spacing is latency+1.
- Reset asserted mid-sequence drops every enable immediately, without waiting for a clock edge. A partially executed command is abandoned with no rsp_valid.

## Configuration
- SEQ_TRISTATE_FN_EN defined: mem_select_fn is driven 2'bzz whenever fn_valid=0, matching RegisterMemory's Z-as-idle decode.
- SEQ_TRISTATE_FN_EN undefined: mem_select_fn is driven 2'b00 when idle, and the memory must qualify Select_Fn with mem_fn_valid.
- mem_fn_valid exists in both builds.

## Test plan
- LDI dst=4 imm=141 -> write_en high for one cycle with address=4, data_in=141; rsp_valid at T+3 with rsp_data=141.
- Model R5=208; MOV src=5 dst=1 -> read_en cycle address=5, then write_en cycle address=1 data_in=208; rsp_data=208 at T+4.
- Model R2=93 after add, flag=4'b0001; ALU fn=00 dst=0 -> one fn_valid cycle with select_fn=00, read of address 2, write of 93 to address 0; rsp_flag=0001 at T+6. Same command with dst=2 -> no write; rsp at T+4.
- READ src=9 (model 32) -> rsp_data=32 at T+2, write_en never asserted. cmd_valid held during busy -> exactly one accept.
- Assert rst during the WR cycle of MOV -> write_en low immediately, no rsp_valid; after release, cmd_ready=1 and the next LDI completes normally.
- Build with and without SEQ_TRISTATE_FN_EN -> idle select_fn equals zz and 00 respectively.
